// File: rtl/cond_unit.sv
// Condition-code unit: holds the NZCV flag register, evaluates instruction
// condition fields, and stalls issue while flag-setting instructions are in flight.
module cond_unit #(
    parameter int MAX_PENDING = 3
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flag_we_i,
    input  logic [3:0]                         flags_i,
    input  logic                               issue_valid_i,
    input  logic [3:0]                         issue_cond_i,
    input  logic                               issue_sets_flags_i,
    input  logic                               flush_i,
    output logic                               issue_ready_o,
    output logic                               exec_valid_o,
    output logic                               exec_o,
    output logic [3:0]                         flags_o,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_o,
    output logic                               err_o
);

    localparam int CW = $clog2(MAX_PENDING + 1);

    // ARM condition evaluation on an NZCV nibble ([3]=N, [2]=Z, [1]=C, [0]=V)
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, res;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'd0:    res = z;
            4'd1:    res = !z;
            4'd2:    res = c;
            4'd3:    res = !c;
            4'd4:    res = n;
            4'd5:    res = !n;
            4'd6:    res = v;
            4'd7:    res = !v;
            4'd8:    res = c && !z;
            4'd9:    res = !c || z;
            4'd10:   res = (n == v);
            4'd11:   res = (n != v);
            4'd12:   res = !z && (n == v);
            4'd13:   res = z || (n != v);
            4'd14:   res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [3:0]    flags_r;
    logic [CW-1:0] pending_r;
    logic [2:0]    win_r;
    logic          err_r;
    logic          exec_valid_r;
    logic          exec_r;

    logic          dec_s;
    logic          inc_s;
    logic [CW-1:0] pend_eff_s;
    logic          needs_s;
    logic          ready_s;
    logic          accept_s;
    logic [3:0]    f_s;
    logic [CW-1:0] pending_nxt_s;
    logic          err_set_s;

    // Issue acceptance, forwarded flags and next pending count
    always_comb begin
        dec_s      = flag_we_i && (pending_r != {CW{1'b0}});
        pend_eff_s = pending_r - CW'(dec_s);
        needs_s    = (issue_cond_i != 4'd14) && (issue_cond_i != 4'd15);
        ready_s    = !flush_i
                     && !(needs_s && (pend_eff_s != {CW{1'b0}}))
                     && !(issue_sets_flags_i && (pend_eff_s == CW'(MAX_PENDING)));
        accept_s   = issue_valid_i && ready_s;
        inc_s      = accept_s && issue_sets_flags_i;
        // A writeback in this cycle is the final value a waiting instruction sees
        if (flag_we_i) begin
            f_s = flags_i;
        end else begin
            f_s = flags_r;
        end
        if (flush_i) begin
            pending_nxt_s = {CW{1'b0}};
        end else begin
            pending_nxt_s = pending_r + CW'(inc_s) - CW'(dec_s);
        end
        // Late writebacks from flushed instructions are tolerated during the window
        err_set_s = flag_we_i && (pending_r == {CW{1'b0}})
                    && (win_r == 3'd0) && !flush_i;
    end

    // Architectural state, flush window and registered issue results
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            flags_r      <= 4'b0000;
            pending_r    <= {CW{1'b0}};
            win_r        <= 3'd0;
            err_r        <= 1'b0;
            exec_valid_r <= 1'b0;
            exec_r       <= 1'b0;
        end else begin
            if (flag_we_i) begin
                flags_r <= flags_i;
            end
            pending_r <= pending_nxt_s;
            if (flush_i) begin
                win_r <= 3'd4;
            end else if (win_r != 3'd0) begin
                win_r <= win_r - 3'd1;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
            exec_valid_r <= accept_s;
            exec_r       <= accept_s && cond_pass(issue_cond_i, f_s);
        end
    end

    assign issue_ready_o = ready_s;
    assign exec_valid_o  = exec_valid_r;
    assign exec_o        = exec_r;
    assign flags_o       = flags_r;
    assign pending_o     = pending_r;
    assign err_o         = err_r;

endmodule

// File: doc/cond_unit.md
# cond_unit

Condition-code unit that consumes the ALU's NZCV status output. It holds the architectural flag register and evaluates the 4-bit condition field of each issued instruction against it. It also tracks in-flight flag-setting instructions and stalls issue until the flags a conditional instruction needs are final. It sits between decode/issue and the ALU writeback, and is the consumer end of the ALU's `status_o`/`set_status_i` path.

## Interface
- `MAX_PENDING`, default 3: maximum in-flight flag-setting instructions; the counter width is clog2(MAX_PENDING+1).

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; one clock, synchronous, active-low.
- `flag_we_i`  in  1  ALU writeback of flags this cycle (the ALU's `set_status_i` result arriving).
- `flags_i`  in  4  flag value from ALU `status_o`: [3]=N, [2]=Z, [1]=C, [0]=V.
- `issue_valid_i`  in  1  an instruction is presented for issue.
- `issue_cond_i`  in  4  condition field of the presented instruction.
- `issue_sets_flags_i`  in  1  the presented instruction will later produce one `flag_we_i`.
- `flush_i`  in  1  discard all in-flight flag writers.
- `issue_ready_o`  out  1  combinational; the presented instruction is accepted this cycle.
- `exec_valid_o`  out  1  registered; one pulse per accepted instruction.
- `exec_o`  out  1  registered; condition passed for that instruction.
- `flags_o`  out  4  current flag register.
- `pending_o`  out  clog2(MAX_PENDING+1)  in-flight flag-setter count.
- `err_o`  out  1  sticky; set by a `flag_we_i` arriving with nothing pending.

## Operation
Condition table (ARM encoding), evaluated on `f` as defined under Flags used for evaluation:
- 0 EQ: Z
- 1 NE: !Z
- 2 CS: C
- 3 CC: !C
- 4 MI: N
- 5 PL: !N
- 6 VS: V
- 7 VC: !V
- 8 HI: C&!Z
- 9 LS: !C|Z
- 10 GE: N==V
- 11 LT: N!=V
- 12 GT: !Z&(N==V)
- 13 LE: Z|(N!=V)
- 14 AL: always pass
- 15 NV: never pass

Codes 14 and 15 do not need flags; all others do.

Derived values:
- `pend_eff` = `pending_q` − (`flag_we_i` && `pending_q`≠0).
- `needs` = `issue_cond_i` ∉ {14, 15}.

Issue acceptance:
- `issue_ready_o` = !`flush_i` && !(`needs` && `pend_eff`≠0) && !(`issue_sets_flags_i` && `pend_eff`==MAX_PENDING).
- Accept = `issue_valid_i` && `issue_ready_o`.

Flags used for evaluation:
- `f` = `flag_we_i` ? `flags_i` : `flags_q`.
- This forwards the final writeback: a conditional instruction issues in the same cycle its last flag writer retires.

Flag register:
- `flag_we_i` writes `flags_i` into `flags_q` unconditionally, including during flush and with `pending_q`==0.

Pending counter, per cycle:
- next = `pending_q` + (accept && `issue_sets_flags_i`) − (`flag_we_i` && `pending_q`≠0).
- Simultaneous increment and decrement leaves the count unchanged.
- `flush_i` forces next = 0 and takes priority over all other updates.
- After a flush, late `flag_we_i` from flushed instructions still update `flags_q`. They do not set `err_o` for 4 cycles after the flush cycle.

Error flag:
- Set when `flag_we_i` && `pending_q`==0 outside that flush window.
- Cleared only by reset.

Outputs:
- `exec_valid_o` <= accept.
- `exec_o` <= accept && cond(`f`). `exec_o` is 0 whenever `exec_valid_o` is 0.

## Timing
Reset values: `flags_o`=4'b0000, `pending_o`=0, `exec_valid_o`=0, `exec_o`=0, `err_o`=0; flush window inactive.
- Reset is honoured mid-operation: all in-flight tracking is lost, and any `flag_we_i` in the reset cycle is ignored.

Latency:
- `issue_ready_o` is the same cycle as its inputs.
- `exec_valid_o`/`exec_o` follow one cycle after acceptance.
- `flags_o`/`pending_o` reflect an update one cycle after the update cycle.

Throughput:
- One accept per cycle when not stalled.
- Back-to-back flag-setters are allowed up to MAX_PENDING outstanding.
- A full counter with a same-cycle writeback accepts another setter.

Handshake:
- Issue inputs may change freely while `issue_ready_o`=0; no state changes on an unaccepted cycle.
- Unconditional (AL/NV) instructions never stall on pending flags.

## Test plan
- Reset, then `flag_we_i`=1 with `flags_i`=4'b0100 and `pending_o`=0 -> `flags_o`=0100, `err_o`=1. Then issue cond 0 (EQ) -> one cycle later `exec_valid_o`=1, `exec_o`=1.
- Issue ADD setting flags, then present cond 1 (NE) next cycle -> `issue_ready_o`=0. When `flag_we_i`=1 with `flags_i`=0000 arrives -> same cycle `issue_ready_o`=1, and one cycle later `exec_o`=1 (forwarded Z=0).
- Issue 3 flag-setters back to back -> `pending_o`=3. A 4th setter stalls. A 4th setter presented with `flag_we_i` in the same cycle is accepted and `pending_o` stays 3.
- Flags N=1, V=0 -> GE gives `exec_o`=0, LT gives 1, GT gives 0, LE gives 1. AL gives 1 and NV gives 0, both issued while `pending_o`=2 with no stall.
- `pending_o`=2, assert `flush_i` -> `issue_ready_o`=0 that cycle and `pending_o`=0 next. Two late `flag_we_i` within 4 cycles -> `flags_o` updated, `err_o` stays 0.
- Drive `rst_ni`=0 for one cycle while `pending_o`=1 and `exec_valid_o`=1 -> next cycle all outputs at reset values.
